// File: rtl/hmac_arb_pkg.sv
// Shared types and widths for the HMAC engine arbiter (hmac_arbiter, hmac_rr_picker).
package hmac_arb_pkg;

  localparam int HashWidth = 256;
  localparam int MsgWidth  = 512;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_HASH = 3'd3,
    ST_RESPOND   = 3'd4,
    ST_DRAIN     = 3'd5
  } state_e;

endpackage

// File: rtl/hmac_rr_picker.sv
// Round-robin picker: returns the first valid index after last_i, wrapping at NumReq-1.
module hmac_rr_picker #(
  parameter  int NumReq = 2,
  localparam int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] valid_i,
  input  logic [IdxW-1:0]   last_i,
  output logic [IdxW-1:0]   grant_o,
  output logic              any_o
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    grant_o = '0;
    idx     = 0;
    for (int off = NumReq; off >= 1; off--) begin
      idx = int'(last_i) + off;
      if (idx >= NumReq) idx = idx - NumReq;
      if (valid_i[idx]) grant_o = IdxW'(idx);
    end
  end

  assign any_o = |valid_i;

endmodule

// File: rtl/hmac_arbiter.sv
// Arbitrates NumReq requesters onto one HMAC engine; the watchdog/Drain path
// is built only when HMAC_ARB_TIMEOUT_EN is defined.
module hmac_arbiter
  import hmac_arb_pkg::*;
#(
  parameter  int NumReq        = 2,
  parameter  int TimeoutCycles = 1024,
  localparam int IdxW          = $clog2(NumReq)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumReq-1:0]          req_valid_i,
  output logic [NumReq-1:0]          req_ready_o,
  input  logic [NumReq*MsgWidth-1:0] req_msg_i,
  output logic [NumReq-1:0]          resp_valid_o,
  output logic [HashWidth-1:0]       resp_hash_o,
  output logic                       resp_err_o,
  output logic                       hmac_init_o,
  output logic [MsgWidth-1:0]        hmac_msg_o,
  input  logic                       hmac_ready_i,
  input  logic                       hmac_valid_i,
  input  logic [HashWidth-1:0]       hmac_hash_i,
  output logic                       busy_o,
  output logic [IdxW-1:0]            grant_o,
  output logic [2:0]                 state_o
);

  if (NumReq < 2 || NumReq > 8 || TimeoutCycles < 1) begin : g_bad_param
    $error("hmac_arbiter: NumReq must be 2..8 and TimeoutCycles >= 1");
  end

  // Handshakes: a request transfers in the cycle req_valid_i[g] && req_ready_o[g]
  // (ready follows valid combinationally, Idle only); the engine takes a job when
  // hmac_init_o && hmac_ready_i; hmac_valid_i is a one-cycle result strobe.
  state_e                 state_q, state_d;
  logic [IdxW-1:0]        grant_q, grant_d;
  logic [IdxW-1:0]        last_q, last_d;
  logic [MsgWidth-1:0]    msg_q, msg_d;
  logic [HashWidth-1:0]   hash_q, hash_d;
  logic [IdxW-1:0]        pick;
  logic                   any_valid;
  logic [MsgWidth-1:0]    msg_sel;
  logic [NumReq-1:0]      ready_vec, resp_vec;
  logic                   init;
  logic                   timeout;
  logic                   err_q;

  hmac_rr_picker #(.NumReq(NumReq)) u_picker (
    .valid_i (req_valid_i),
    .last_i  (last_q),
    .grant_o (pick),
    .any_o   (any_valid)
  );

  assign msg_sel = req_msg_i[int'(pick)*MsgWidth +: MsgWidth];

`ifdef HMAC_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_d;

  // A result arriving in the same cycle as the limit still wins.
  assign timeout = (state_q inside {ST_START, ST_WAIT_BUSY, ST_WAIT_HASH}) &&
                   (cnt_q == CntW'(TimeoutCycles - 1)) &&
                   !(state_q == ST_WAIT_HASH && hmac_valid_i);

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
      end
      ST_START, ST_WAIT_BUSY, ST_WAIT_HASH: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_q   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    msg_d     = msg_q;
    hash_d    = hash_q;
    ready_vec = '0;
    resp_vec  = '0;
    init      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          ready_vec[pick] = 1'b1;
          grant_d         = pick;
          last_d          = pick;
          msg_d           = msg_sel;
          state_d         = ST_START;
        end
      end
      ST_START: begin
        if (hmac_ready_i) begin
          init    = 1'b1;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: if (!hmac_ready_i) state_d = ST_WAIT_HASH;
      ST_WAIT_HASH: begin
        if (hmac_valid_i) begin
          hash_d  = hmac_hash_i;
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        resp_vec[grant_q] = 1'b1;
        state_d           = err_q ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: if (hmac_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abandoned job: report a zero hash and flag it as an error.
    if (timeout) begin
      init    = 1'b0;
      hash_d  = '0;
      state_d = ST_RESPOND;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IdxW'(NumReq - 1);
      msg_q   <= '0;
      hash_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      msg_q   <= msg_d;
      hash_q  <= hash_d;
    end
  end

  assign req_ready_o  = rst_i ? '0 : ready_vec;
  assign resp_valid_o = resp_vec;
  assign resp_hash_o  = hash_q;
  assign resp_err_o   = err_q && (state_q == ST_RESPOND);
  assign hmac_init_o  = init;
  assign hmac_msg_o   = msg_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign grant_o      = grant_q;
  assign state_o      = state_q;

endmodule

// File: doc/hmac_arbiter.md
HMAC_ARBITER -- requirements
Module: hmac_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of requesters sharing one HMAC engine (range 2..8).
REQ-002 SHALL have parameter TimeoutCycles, default 1024, watchdog limit in clk_i cycles (used only under REQ-030).
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port: clk_i  in  1  sole clock.
REQ-005 SHALL have port: rst_i  in  1  asynchronous active-high reset.
REQ-006 SHALL have port: req_valid_i  in  NumReq  per-requester hash request.
REQ-007 SHALL have port: req_ready_o  out  NumReq  per-requester accept, at most one bit high.
REQ-008 SHALL have port: req_msg_i  in  NumReq*512  per-requester message, slice i = bits [512*i+511:512*i].
REQ-009 SHALL have port: resp_valid_o  out  NumReq  one-cycle completion pulse, at most one bit high.
REQ-010 SHALL have port: resp_hash_o  out  256  result of the last completed job, shared by all requesters.
REQ-011 SHALL have port: resp_err_o  out  1  qualifies resp_valid_o; high means the job timed out.
REQ-012 SHALL have engine ports: hmac_init_o out 1; hmac_msg_o out 512; hmac_ready_i in 1; hmac_valid_i in 1; hmac_hash_i in 256.
REQ-013 SHALL have port: busy_o  out  1  high whenever state is not Idle.
REQ-014 SHALL have port: grant_o  out  $clog2(NumReq)  index of the current or last grant.

Function
REQ-015 SHALL implement states Idle, Start, WaitBusy, WaitHash, Respond, Drain.
REQ-016 Idle: if any req_valid_i bit is set, SHALL drive req_ready_o[g] high combinationally in that cycle, latch req_msg_i slice g and g, and go to Start.
REQ-017 Grant g SHALL be round-robin: the first valid index after the last granted index, wrapping from NumReq-1 to 0.
REQ-018 Start: SHALL drive hmac_init_o high for exactly one cycle in the first cycle hmac_ready_i=1, then go to WaitBusy; otherwise SHALL stay in Start.
REQ-019 WaitBusy: SHALL go to WaitHash on hmac_ready_i=0.
REQ-020 WaitHash: on hmac_valid_i=1, SHALL latch hmac_hash_i into resp_hash_o and go to Respond.
REQ-021 Respond: SHALL drive resp_valid_o[g]=1 for one cycle, then go to Idle. With ready engines, accept-to-response latency is (engine latency + 3) cycles.
REQ-022 hmac_msg_o SHALL hold the latched message from acceptance until the next acceptance.
REQ-023 req_ready_o SHALL be all-zero outside Idle; requests arriving while busy SHALL wait, and a requester may drop valid before acceptance without side effect.
REQ-024 A requester with valid held continuously SHALL be granted within NumReq jobs.
REQ-025 resp_hash_o SHALL be stable between Respond pulses; hmac_valid_i outside WaitHash SHALL be ignored.

Reset
REQ-026 On rst_i, the block SHALL enter Idle and SHALL zero req_ready_o, resp_valid_o, resp_err_o, hmac_init_o, busy_o, resp_hash_o, hmac_msg_o and grant_o.
REQ-027 On rst_i, the round-robin pointer SHALL be set to NumReq-1 so that requester 0 wins first.
REQ-028 A reset mid-job SHALL abandon the job with no response pulse.

Configuration
REQ-029 Without HMAC_ARB_TIMEOUT_EN, resp_err_o SHALL be tied 0, no counter SHALL exist, and Drain SHALL be unreachable.
REQ-030 With HMAC_ARB_TIMEOUT_EN, a counter SHALL clear on entry to Start and increment in Start, WaitBusy and WaitHash; on reaching TimeoutCycles, the block SHALL zero resp_hash_o and go to Respond with resp_err_o=1, then go to Drain, which waits for hmac_ready_i=1 before returning to Idle.

Structure
REQ-031 Package hmac_arb_pkg SHALL hold the state enum, HashWidth=256 and MsgWidth=512.
REQ-032 Round-robin selection SHALL be the sub-module hmac_rr_picker (inputs: valid vector and last index; outputs: grant index and any-valid).

Verification
REQ-033 Single job: req_valid_i=2'b01, msg=512'h61626380, engine hash 256'hAB..CD after 64 cycles -> resp_valid_o=2'b01 with resp_hash_o=256'hAB..CD, 67 cycles after accept.
REQ-034 Contention: both requesters valid continuously for 4 jobs -> grants 0,1,0,1.
REQ-035 Engine not ready: hmac_ready_i=0 for 10 cycles after accept -> hmac_init_o pulses once, in the cycle ready rises.
REQ-036 Reset at WaitHash: rst_i pulsed -> busy_o=0 and no resp_valid_o; the next request to requester 0 completes normally.
REQ-037 HMAC_ARB_TIMEOUT_EN, TimeoutCycles=16, hmac_valid_i never set -> resp_err_o=1, resp_hash_o=0 at cycle 16; the block stays in Drain until hmac_ready_i=1.
